// File: rtl/dlf_cmd_sequencer_pkg.sv
// Shared definitions for the DLFloat16 command sequencer: FSM encoding,
// ALU select codes and the layout of a stored result.
package dlf_cmd_sequencer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Operation select codes understood by the dl_float ALU.
   localparam logic [2:0] SEL_ADD  = 3'd0;
   localparam logic [2:0] SEL_SUB  = 3'd1;
   localparam logic [2:0] SEL_MUL  = 3'd2;
   localparam logic [2:0] SEL_DIV  = 3'd3;
   localparam logic [2:0] SEL_MAC  = 3'd4;
   localparam logic [2:0] SEL_SQRT = 3'd5;
   localparam logic [2:0] SEL_NORM = 3'd6;
   localparam logic [2:0] SEL_DP   = 3'd7;

   localparam int SEL_W  = 3;
   localparam int DATA_W = 16;
   localparam int RES_W  = SEL_W + DATA_W;
   localparam int CNT_W  = 4;

   // A FIFO entry is {select, result} so the consumer knows which op produced it.
   function automatic logic [RES_W-1:0] pack_res(input logic [SEL_W-1:0] sel,
                                                 input logic [DATA_W-1:0] data);
      return {sel, data};
   endfunction

endpackage

// File: rtl/dlf_cmd_sequencer_res_fifo.sv
// Result FIFO: registered storage, first-word-fall-through head, power-of-two depth
// with free-running pointers that wrap modulo DEPTH.
module dlf_res_fifo
   import dlf_cmd_sequencer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = RES_W
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_valid,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_pop;

   // Popping an empty FIFO is a no-op.
   assign w_pop   = i_pop && (r_count != '0);
   assign o_valid = (r_count != '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_rdata = r_mem[r_rptr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wptr] <= i_wdata;
   end

   a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_push && o_full && !i_pop));

endmodule

// File: rtl/dlf_cmd_sequencer.sv
// Issues one DLFloat16 command at a time to the dl_float ALU, waits LAT cycles
// for the result to settle, then queues {select, result} in a small FIFO.
module dlf_cmd_sequencer
   import dlf_cmd_sequencer_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_sel,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic [2:0]  alu_sel,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic [15:0] alu_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic [2:0]  res_sel,
   output logic        busy,
   output state_t      dbg_state
);

   // Handshake: a transfer happens on an edge where valid and ready are both high;
   // ready never looks at valid, and the head stays put until it is taken.
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_alu_sel;
   logic [15:0]      r_alu_a;
   logic [15:0]      r_alu_b;

   logic             w_full;
   logic             w_accept;
   logic             w_push;
   logic [RES_W-1:0] w_fifo_rdata;

   assign cmd_ready = (r_state == ST_IDLE) && !w_full;
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_push    = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_alu_sel <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_alu_sel <= cmd_sel;
                  r_alu_a   <= cmd_a;
                  r_alu_b   <= cmd_b;
                  r_cnt     <= CNT_W'(LAT);
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Operands stay frozen; the result is captured on the edge leaving WAIT.
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) r_state <= ST_IDLE;
            end
         endcase
      end
   end

   dlf_res_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RES_W)
   ) u_res_fifo (
      .i_clk   (clk),
      .i_rst   (rst_n),
      .i_push  (w_push),
      .i_wdata (pack_res(r_alu_sel, alu_result)),
      .i_pop   (res_ready),
      .o_rdata (w_fifo_rdata),
      .o_valid (res_valid),
      .o_full  (w_full)
   );

   assign {res_sel, res_data} = w_fifo_rdata;
   assign alu_sel   = r_alu_sel;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign busy      = (r_state != ST_IDLE) || res_valid;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_dlf_cmd_sequencer.sv
// Bench for dlf_cmd_sequencer: a stand-in ALU whose output settles LAT-1 edges
// after its operands change, and a queue-based reference of commands and results.
`timescale 1ns/1ps
module tb_dlf_cmd_sequencer;
   import dlf_cmd_sequencer_pkg::*;

   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_sel = '0;
   logic [15:0] cmd_a = '0;
   logic [15:0] cmd_b = '0;
   logic [2:0]  alu_sel;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic [2:0]  res_sel;
   logic        busy;
   state_t      dbg_state;

   always #5 clk = ~clk;

   dlf_cmd_sequencer #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sel(res_sel),
      .busy(busy), .dbg_state(dbg_state)
   );

   // Stand-in ALU: arbitrary mixing function, output only valid LAT-1 edges after an operand change.
   function automatic logic [15:0] alu_fn(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
      return (a + {b[7:0], b[15:8]}) ^ {s, 13'h0A5} ^ (a << 3);
   endfunction

   logic [15:0] alu_pipe [LAT];
   always @(posedge clk) begin
      alu_pipe[0] <= alu_fn(alu_sel, alu_a, alu_b);
      for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
   end
   assign alu_result = (LAT == 1) ? alu_fn(alu_sel, alu_a, alu_b) : alu_pipe[(LAT > 1) ? LAT-2 : 0];

   // Reference: at most one command in flight, result available LAT edges after acceptance.
   logic [18:0] exp_q[$];
   int          m_wait = 0;
   logic [18:0] m_fly;
   logic [2:0]  m_sel = '0;
   logic [15:0] m_a = '0;
   logic [15:0] m_b = '0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          acc_cnt = 0;
   int          pop_cnt = 0;
   int          acc_cyc[$];

   task automatic model_reset();
      exp_q.delete();
      m_wait = 0;
      m_sel = '0; m_a = '0; m_b = '0;
   endtask

   // Advance one clock, updating the reference from the inputs held across the edge.
   task automatic tick();
      bit m_ready, acc, pop, push;
      @(posedge clk);
      m_ready = (m_wait == 0) && (exp_q.size() < DEPTH);
      acc  = cmd_valid && m_ready;
      pop  = res_ready && (exp_q.size() > 0);
      push = (m_wait == 1);
      if (pop) begin void'(exp_q.pop_front()); pop_cnt++; end
      if (push) exp_q.push_back(m_fly);
      if (m_wait > 0) m_wait--;
      if (acc) begin
         m_wait = LAT;
         m_sel = cmd_sel; m_a = cmd_a; m_b = cmd_b;
         m_fly = {cmd_sel, alu_fn(cmd_sel, cmd_a, cmd_b)};
         acc_cnt++;
         acc_cyc.push_back(cyc);
      end
      cyc++;
      #1;
   endtask

   task automatic rand_cmd();
      cmd_sel = 3'($urandom_range(0, 7));
      cmd_a   = 16'($urandom);
      cmd_b   = 16'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if ({alu_sel, alu_a, alu_b} !== 35'd0) begin errors++; $display("FAIL reset_alu got %h exp 0", {alu_sel, alu_a, alu_b}); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %b exp %b", dbg_state, ST_IDLE); end
      rst_n = 1'b0;
      model_reset();
      tick();
      checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL post_reset got rdy=%b vld=%b exp rdy=1 vld=0", cmd_ready, res_valid); end
   endtask

   task automatic test_single();
      logic [15:0] exp_d;
      exp_d = alu_fn(SEL_ADD, 16'h3E00, 16'h3E00);
      res_ready = 1'b0;
      cmd_valid = 1'b1; cmd_sel = SEL_ADD; cmd_a = 16'h3E00; cmd_b = 16'h3E00;
      tick();
      cmd_valid = 1'b0; rand_cmd();
      checks++; if ({alu_sel, alu_a, alu_b} !== {SEL_ADD, 16'h3E00, 16'h3E00}) begin errors++; $display("FAIL single_alu got %h exp %h", {alu_sel, alu_a, alu_b}, {SEL_ADD, 16'h3E00, 16'h3E00}); end
      checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_wait got rdy=%b busy=%b exp rdy=0 busy=1", cmd_ready, busy); end
      tick();
      checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL single_k1 got vld=%b rdy=%b exp vld=0 rdy=0", res_valid, cmd_ready); end
      tick();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", res_valid); end
      checks++; if (res_data !== exp_d) begin errors++; $display("FAIL single_data got %h exp %h", res_data, exp_d); end
      checks++; if (res_sel !== SEL_ADD) begin errors++; $display("FAIL single_sel got %0d exp %0d", res_sel, SEL_ADD); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back got %b exp 1", cmd_ready); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_pop got vld=%b busy=%b exp 0 0", res_valid, busy); end
   endtask

   task automatic test_back_to_back();
      int start, pstart, guard;
      bit e_rdy;
      start = acc_cnt; pstart = pop_cnt; guard = 0;
      acc_cyc.delete();
      res_ready = 1'b1; cmd_valid = 1'b1;
      while ((acc_cnt - start < 8 || m_wait != 0 || exp_q.size() != 0) && guard < 200) begin
         cmd_valid = (acc_cnt - start < 8);
         rand_cmd();
         e_rdy = (m_wait == 0) && (exp_q.size() < DEPTH);
         checks++; if (cmd_ready !== e_rdy) begin errors++; $display("FAIL b2b_ready cyc=%0d got %b exp %b", cyc, cmd_ready, e_rdy); end
         if (exp_q.size() > 0) begin
            checks++; if (res_valid !== 1'b1 || {res_sel, res_data} !== exp_q[0]) begin errors++; $display("FAIL b2b_head cyc=%0d got %b/%h exp 1/%h", cyc, res_valid, {res_sel, res_data}, exp_q[0]); end
         end
         tick(); guard++;
      end
      cmd_valid = 1'b0; res_ready = 1'b0;
      checks++; if (guard >= 200) begin errors++; $display("FAIL b2b_timeout got %0d cycles exp <200", guard); end
      checks++; if (pop_cnt - pstart !== 8) begin errors++; $display("FAIL b2b_pops got %0d exp 8", pop_cnt - pstart); end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         checks++; if (acc_cyc[i] - acc_cyc[i-1] != LAT + 1) begin errors++; $display("FAIL b2b_spacing idx=%0d got %0d exp %0d", i, acc_cyc[i] - acc_cyc[i-1], LAT + 1); end
      end
   endtask

   task automatic test_backpressure();
      int start, pstart, guard;
      bit e_rdy;
      start = acc_cnt; pstart = pop_cnt;
      res_ready = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 5 * (LAT + 1) + 6; i++) begin
         cmd_valid = (acc_cnt - start < 5);
         rand_cmd();
         e_rdy = (m_wait == 0) && (exp_q.size() < DEPTH);
         checks++; if (cmd_ready !== e_rdy) begin errors++; $display("FAIL bp_ready cyc=%0d got %b exp %b", cyc, cmd_ready, e_rdy); end
         if (exp_q.size() > 0) begin
            checks++; if ({res_sel, res_data} !== exp_q[0]) begin errors++; $display("FAIL bp_hold cyc=%0d got %h exp %h", cyc, {res_sel, res_data}, exp_q[0]); end
         end
         tick();
      end
      checks++; if (acc_cnt - start !== DEPTH) begin errors++; $display("FAIL bp_stored got %0d exp %0d", acc_cnt - start, DEPTH); end
      checks++; if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_full got rdy=%b vld=%b busy=%b exp 0 1 1", cmd_ready, res_valid, busy); end
      res_ready = 1'b1; guard = 0;
      while ((pop_cnt - pstart < 5) && guard < 100) begin
         cmd_valid = (acc_cnt - start < 5);
         rand_cmd();
         if (exp_q.size() > 0) begin
            checks++; if (res_valid !== 1'b1 || {res_sel, res_data} !== exp_q[0]) begin errors++; $display("FAIL bp_drain cyc=%0d got %b/%h exp 1/%h", cyc, res_valid, {res_sel, res_data}, exp_q[0]); end
         end
         tick(); guard++;
      end
      cmd_valid = 1'b0; res_ready = 1'b0;
      checks++; if (pop_cnt - pstart !== 5 || acc_cnt - start !== 5) begin errors++; $display("FAIL bp_total got acc=%0d pop=%0d exp 5 5", acc_cnt - start, pop_cnt - pstart); end
   endtask

   task automatic test_full_pop_same_edge();
      int start, guard;
      bit did_sim, e_rdy;
      for (int r = 0; r < 4; r++) begin
         start = acc_cnt; did_sim = 0; guard = 0;
         while ((acc_cnt - start < DEPTH + 1 || m_wait != 0) && guard < 200) begin
            cmd_valid = (acc_cnt - start < DEPTH + 1);
            res_ready = (!did_sim && m_wait == 1 && exp_q.size() == DEPTH - 1);
            if (res_ready) did_sim = 1;
            rand_cmd();
            e_rdy = (m_wait == 0) && (exp_q.size() < DEPTH);
            checks++; if (cmd_ready !== e_rdy) begin errors++; $display("FAIL full_ready r=%0d cyc=%0d got %b exp %b", r, cyc, cmd_ready, e_rdy); end
            if (exp_q.size() > 0) begin
               checks++; if (res_valid !== 1'b1 || {res_sel, res_data} !== exp_q[0]) begin errors++; $display("FAIL full_head r=%0d cyc=%0d got %b/%h exp 1/%h", r, cyc, res_valid, {res_sel, res_data}, exp_q[0]); end
            end
            tick(); guard++;
         end
         res_ready = 1'b0;
         checks++; if (guard >= 200) begin errors++; $display("FAIL full_timeout r=%0d got %0d cycles exp <200", r, guard); end
         checks++; if (cmd_ready !== 1'b0 || res_valid !== 1'b1) begin errors++; $display("FAIL full_state r=%0d got rdy=%b vld=%b exp 0 1", r, cmd_ready, res_valid); end
         cmd_valid = 1'b1; res_ready = 1'b1; rand_cmd();
         tick();
         cmd_valid = 1'b0;
         checks++; if (cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL full_pop_no_acc r=%0d got rdy=%b st=%b exp 1 0", r, cmd_ready, dbg_state); end
         guard = 0;
         while ((exp_q.size() != 0) && guard < 50) begin
            checks++; if (res_valid !== 1'b1 || {res_sel, res_data} !== exp_q[0]) begin errors++; $display("FAIL full_drain r=%0d cyc=%0d got %b/%h exp 1/%h", r, cyc, res_valid, {res_sel, res_data}, exp_q[0]); end
            tick(); guard++;
         end
         res_ready = 1'b0;
         checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL full_empty r=%0d got %b exp 0", r, res_valid); end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] exp_d;
      cmd_valid = 1'b1; res_ready = 1'b0; rand_cmd();
      tick();
      cmd_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got rdy=%b vld=%b busy=%b exp 1 0 0", cmd_ready, res_valid, busy); end
      checks++; if ({alu_sel, alu_a, alu_b} !== 35'd0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL mid_rst_alu got %h st=%b exp 0 0", {alu_sel, alu_a, alu_b}, dbg_state); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < LAT + 3; i++) begin
         checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_no_result i=%0d got vld=%b busy=%b exp 0 0", i, res_valid, busy); end
         tick();
      end
      cmd_valid = 1'b1; cmd_sel = SEL_MUL; cmd_a = 16'h4100; cmd_b = 16'h3F80;
      exp_d = alu_fn(SEL_MUL, 16'h4100, 16'h3F80);
      tick();
      cmd_valid = 1'b0;
      repeat (LAT) tick();
      checks++; if (res_valid !== 1'b1 || res_data !== exp_d || res_sel !== SEL_MUL) begin errors++; $display("FAIL mid_rst_next got %b/%0d/%h exp 1/%0d/%h", res_valid, res_sel, res_data, SEL_MUL, exp_d); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_random(input int n, input int rbias);
      bit e_rdy, e_busy;
      int guard;
      for (int i = 0; i < n; i++) begin
         cmd_valid = ($urandom_range(0, 3) != 0);
         res_ready = ($urandom_range(0, 3) < rbias);
         rand_cmd();
         e_rdy  = (m_wait == 0) && (exp_q.size() < DEPTH);
         e_busy = (m_wait != 0) || (exp_q.size() != 0);
         checks++; if (cmd_ready !== e_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, cmd_ready, e_rdy); end
         checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got %b exp %b", cyc, busy, e_busy); end
         checks++; if ({alu_sel, alu_a, alu_b} !== {m_sel, m_a, m_b}) begin errors++; $display("FAIL rnd_alu cyc=%0d got %h exp %h", cyc, {alu_sel, alu_a, alu_b}, {m_sel, m_a, m_b}); end
         checks++; if (res_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, res_valid, exp_q.size() != 0); end
         if (exp_q.size() > 0) begin
            checks++; if ({res_sel, res_data} !== exp_q[0]) begin errors++; $display("FAIL rnd_head cyc=%0d got %h exp %h", cyc, {res_sel, res_data}, exp_q[0]); end
         end
         tick();
      end
      cmd_valid = 1'b0; res_ready = 1'b1; guard = 0;
      while ((exp_q.size() != 0 || m_wait != 0) && guard < 100) begin
         if (exp_q.size() > 0) begin
            checks++; if (res_valid !== 1'b1 || {res_sel, res_data} !== exp_q[0]) begin errors++; $display("FAIL rnd_drain cyc=%0d got %b/%h exp 1/%h", cyc, res_valid, {res_sel, res_data}, exp_q[0]); end
         end
         tick(); guard++;
      end
      res_ready = 1'b0;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_idle got vld=%b busy=%b exp 0 0", res_valid, busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_full_pop_same_edge();
      test_reset_mid_op();
      test_random(300, 3);
      test_random(300, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dlf_cmd_sequencer.md
DLF_CMD_SEQUENCER -- requirements
Module: dlf_cmd_sequencer

Interface
REQ-001 Parameter LAT, default 2: cycles from alu_* operand update to a stable alu_result; legal range 1..15.
REQ-002 Parameter DEPTH, default 4: result FIFO entries; power of two, at least 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous reset, active-high despite the name; the port name matches the codebase.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-008 cmd_sel  in  3  DLFloat16 operation select, passed through to the ALU.
REQ-009 cmd_a, cmd_b  in  16  DLFloat16 operands.
REQ-010 alu_sel  out  3  registered select driving the dl_float ALU.
REQ-011 alu_a, alu_b  out  16  registered operands driving the dl_float ALU.
REQ-012 alu_result  in  16  ALU result.
REQ-013 res_valid  out  1  FIFO head valid.
REQ-014 res_ready  in  1  consumer accepts the head.
REQ-015 res_data  out  16  head result.
REQ-016 res_sel  out  3  select that produced the head result.
REQ-017 busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-018 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-019 cmd_ready SHALL be 1 only in IDLE with FIFO count < DEPTH; it is combinational from state and count and never depends on cmd_valid.
REQ-020 Accept (cmd_valid & cmd_ready at edge k) SHALL load alu_sel/a/b from cmd_*, load the 4-bit counter with LAT, and enter WAIT.
REQ-021 In WAIT the counter SHALL decrement every cycle; alu_sel/a/b SHALL hold stable.
REQ-022 In WAIT with counter==1, the next edge SHALL push {alu_sel, alu_result} into the FIFO and return to IDLE, so capture occurs at edge k+LAT.
REQ-023 alu_* SHALL hold their last values in IDLE; they change only on accept.
REQ-024 Sustained throughput SHALL be one command per LAT+1 cycles, with at most one command in flight.
REQ-025 FIFO: res_valid = count!=0; res_data/res_sel show the head, registered storage, first-word-fall-through.
REQ-026 A pop (res_valid & res_ready) SHALL advance the read pointer; a pop on an empty FIFO SHALL be ignored.
REQ-027 Pointers are log2(DEPTH) bits and SHALL wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-028 A push and a pop on the same edge SHALL leave count unchanged and be valid when the FIFO is full.
REQ-029 A push while full is impossible by REQ-019; an assertion SHALL flag it.
REQ-030 res_data/res_sel SHALL be stable while res_valid & !res_ready.

Reset
REQ-031 Reset SHALL force state IDLE, counter 0, pointers and count 0, alu_sel 0, alu_a 0, alu_b 0, res_valid 0, busy 0, cmd_ready 1.
REQ-032 Reset mid-WAIT SHALL discard the in-flight command; no result is pushed.
REQ-033 FIFO storage need not be reset; res_data SHALL be ignored while res_valid is 0.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding and the 3-bit ALU select codes (ADD, SUB, MUL, DIV, MAC, SQRT, NORM, DP) used by dl_float.
REQ-035 The FIFO SHALL be the sub-module dlf_res_fifo (parameters DEPTH and WIDTH=19); the FSM and counter stay in the top level.

Verification
REQ-036 Single command: LAT=2, accept sel=ADD, a=16'h3E00, b=16'h3E00 at edge k -> alu_a=16'h3E00 from k+1; push at k+2; res_valid=1 after k+2 with res_data equal to the alu_result sampled at k+2 and res_sel=ADD.
REQ-037 Back-to-back: cmd_valid held high with 8 commands, res_ready=1 -> one accept every 3 cycles; 8 results in order; cmd_ready low in WAIT.
REQ-038 Backpressure: res_ready=0 with 5 commands, DEPTH=4 -> 4 results stored, then cmd_ready=0; raise res_ready -> 5th accepted, all 5 popped in order.
REQ-039 Full plus simultaneous events: FIFO full and a pop on the same edge a push completes -> count stays 4, no loss, pointers wrap correctly over 3 or more full cycles.
REQ-040 Reset mid-op: assert rst_n one cycle after accept -> all outputs at REQ-031 values, no result ever appears; the next command works normally.
